// File: rtl/xor_cksum_pkg.sv
// Shared constants for the XOR frame checksum block: default widths and FSM state encodings.
package xor_cksum_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_CNT_W  = 8;

  typedef logic [1:0] state_t;
  localparam state_t IDLE  = 2'd0;
  localparam state_t ACCUM = 2'd1;
  localparam state_t HOLD  = 2'd2;
endpackage

// File: rtl/xor_cksum_acc.sv
// Checksum fold step: acc_next from acc and one input byte.
// XOR_CKSUM_ROTATE_EN selects the order-sensitive rotate-then-XOR fold.
module xor_cksum_acc
  import xor_cksum_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [DATA_W-1:0] acc,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] acc_next
);
`ifdef XOR_CKSUM_ROTATE_EN
  assign acc_next = {acc[DATA_W-2:0], acc[DATA_W-1]} ^ in_data;
`else
  assign acc_next = acc ^ in_data;
`endif
endmodule

// File: rtl/xor_frame_checksum.sv
// Folds each in_last-delimited frame into an XOR checksum plus saturating beat count,
// and holds the result on a valid/ready port. Optional macro: XOR_CKSUM_ROTATE_EN.
module xor_frame_checksum
  import xor_cksum_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              sum_valid,
  input  logic              sum_ready,
  output logic [DATA_W-1:0] sum_data,
  output logic [CNT_W-1:0]  sum_count,
  output logic              sum_ovf
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t            state;
  logic [DATA_W-1:0] acc, acc_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic              ovf, ovf_next;
  logic              accept;

  xor_cksum_acc #(.DATA_W(DATA_W)) u_acc (
    .acc      (acc),
    .in_data  (in_data),
    .acc_next (acc_next)
  );

  assign in_ready = (state != HOLD);
  assign accept   = in_valid && in_ready;

  // Count sticks at max; any attempted increment past it flags overflow.
  assign cnt_next = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
  assign ovf_next = ovf | (cnt == CNT_MAX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      sum_valid <= 1'b0;
      sum_data  <= '0;
      sum_count <= '0;
      sum_ovf   <= 1'b0;
    end else if (accept) begin
      if (in_last) begin
        sum_data  <= acc_next;
        sum_count <= cnt_next;
        sum_ovf   <= ovf_next;
        sum_valid <= 1'b1;
        acc       <= '0;
        cnt       <= '0;
        ovf       <= 1'b0;
        state     <= HOLD;
      end else begin
        acc   <= acc_next;
        cnt   <= cnt_next;
        ovf   <= ovf_next;
        state <= ACCUM;
      end
    end else if (state == HOLD && sum_ready) begin
      sum_valid <= 1'b0;
      state     <= IDLE;
    end
  end
endmodule

// File: tb/tb_xor_frame_checksum.sv
// Directed bench for xor_frame_checksum: default-width DUT plus a CNT_W=3 DUT for saturation.
module tb_xor_frame_checksum;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       in_valid = 1'b0, in_last = 1'b0, sum_ready = 1'b1;
  logic [7:0] in_data = '0;
  logic       in_ready, sum_valid, sum_ovf;
  logic [7:0] sum_data, sum_count;

  logic       v2 = 1'b0, l2 = 1'b0, sr2 = 1'b1;
  logic [7:0] d2 = '0;
  logic       rdy2, sv2, ovf2;
  logic [7:0] sd2;
  logic [2:0] sc2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  xor_frame_checksum #(.DATA_W(8), .CNT_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .sum_valid(sum_valid), .sum_ready(sum_ready),
    .sum_data(sum_data), .sum_count(sum_count), .sum_ovf(sum_ovf)
  );

  xor_frame_checksum #(.DATA_W(8), .CNT_W(3)) dut3 (
    .clk(clk), .reset_n(reset_n), .in_valid(v2), .in_ready(rdy2),
    .in_data(d2), .in_last(l2), .sum_valid(sv2), .sum_ready(sr2),
    .sum_data(sd2), .sum_count(sc2), .sum_ovf(ovf2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic [7:0] d, input logic last);
    in_valid = 1'b1; in_data = d; in_last = last;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic drive3(input logic [7:0] d, input logic last);
    v2 = 1'b1; d2 = d; l2 = last;
    @(posedge clk); #1;
    v2 = 1'b0; l2 = 1'b0;
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 10 && !in_ready; n++) begin
      @(posedge clk); #1;
    end
    chk("idle_timeout", in_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    #2;
    chk("rst_valid", sum_valid, 0);
    chk("rst_data",  sum_data, 0);
    chk("rst_count", sum_count, 0);
    chk("rst_ovf",   sum_ovf, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_count3", sc2, 0);
    #10 reset_n = 1'b1;
    @(posedge clk); #1;

    // basic 3-beat frame, immediate drain
    drive(8'h05, 0); drive(8'h0F, 0); drive(8'hF0, 1);
    chk("f1_valid", sum_valid, 1);
    chk("f1_data",  sum_data, 8'hFA);
    chk("f1_count", sum_count, 3);
    chk("f1_ovf",   sum_ovf, 0);
    chk("f1_hold_rdy", in_ready, 0);
    @(posedge clk); #1;
    chk("f1_drained", sum_valid, 0);
    chk("f1_idle", in_ready, 1);

    // backpressure: result held, no beats taken
    sum_ready = 1'b0;
    drive(8'h05, 0); drive(8'h0F, 0); drive(8'hF0, 1);
    in_valid = 1'b1; in_data = 8'h11;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("bp_rdy",   in_ready, 0);
      chk("bp_valid", sum_valid, 1);
      chk("bp_data",  sum_data, 8'hFA);
      chk("bp_count", sum_count, 3);
    end
    in_valid = 1'b0; sum_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release", sum_valid, 0);
    chk("bp_retain",  sum_data, 8'hFA);
    drive(8'h11, 1);
    chk("bp_fresh_data",  sum_data, 8'h11);
    chk("bp_fresh_count", sum_count, 1);

    // two equal bytes
    wait_idle();
    drive(8'h01, 0); drive(8'h01, 1);
`ifdef XOR_CKSUM_ROTATE_EN
    chk("pair_data", sum_data, 8'h03);
`else
    chk("pair_data", sum_data, 8'h00);
`endif
    chk("pair_count", sum_count, 2);

    // single-beat frame
    wait_idle();
    drive(8'hA5, 1);
    chk("single_data",  sum_data, 8'hA5);
    chk("single_count", sum_count, 1);

    // asynchronous reset mid-frame
    wait_idle();
    drive(8'h12, 0); drive(8'h34, 0);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_data",  sum_data, 0);
    chk("arst_count", sum_count, 0);
    chk("arst_valid", sum_valid, 0);
    #3 reset_n = 1'b1;
    chk("arst_ready", in_ready, 1);
    @(posedge clk); #1;
    drive(8'h3C, 1);
    chk("arst_new_data",  sum_data, 8'h3C);
    chk("arst_new_count", sum_count, 1);

    // idle gaps between beats
    wait_idle();
    drive(8'h01, 0); @(posedge clk); #1;
    drive(8'h02, 0); @(posedge clk); #1;
    drive(8'h04, 0); @(posedge clk); #1;
    drive(8'h08, 1);
`ifdef XOR_CKSUM_ROTATE_EN
    chk("gap_data", sum_data, 8'h00);
`else
    chk("gap_data", sum_data, 8'h0F);
`endif
    chk("gap_count", sum_count, 4);

    // saturation on the 3-bit counter instance
    for (int i = 0; i < 8; i++) drive3(8'h01, 0);
    drive3(8'h01, 1);
    chk("sat_valid", sv2, 1);
    chk("sat_count", sc2, 7);
    chk("sat_ovf",   ovf2, 1);
`ifdef XOR_CKSUM_ROTATE_EN
    chk("sat_data", sd2, 8'hFE);
`else
    chk("sat_data", sd2, 8'h01);
`endif
    @(posedge clk); #1;
    chk("sat_idle", rdy2, 1);
    drive3(8'h02, 1);
    chk("sat_next_ovf",   ovf2, 0);
    chk("sat_next_count", sc2, 1);
    chk("sat_next_data",  sd2, 8'h02);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
